// File: rtl/proc_pkg.sv
// Shared definitions for the 10-bit processor: instruction layout, opcodes,
// ALU operations and timestep encodings. Imported by the sequencer, ALU and
// register file.
package proc_pkg;

  localparam int unsigned INSTR_W = 10;
  localparam int unsigned OPC_W   = 4;
  localparam int unsigned RFLD_W  = 2;
  localparam int unsigned TIME_W  = 2;

  typedef enum logic [OPC_W-1:0] {
    OP_LOAD = 4'd0,
    OP_COPY = 4'd1,
    OP_ADD  = 4'd2,
    OP_SUB  = 4'd3,
    OP_INV  = 4'd4
  } opcode_t;

  typedef enum logic [1:0] {
    ALU_ADD  = 2'd0,
    ALU_SUB  = 2'd1,
    ALU_INV  = 2'd2,
    ALU_PASS = 2'd3
  } alu_op_t;

  localparam logic [TIME_W-1:0] T0 = 2'd0;
  localparam logic [TIME_W-1:0] T1 = 2'd1;
  localparam logic [TIME_W-1:0] T2 = 2'd2;
  localparam logic [TIME_W-1:0] T3 = 2'd3;

  // Instruction word: opcode, destination Rx, source Ry, two spare bits.
  typedef struct packed {
    logic [OPC_W-1:0]  opcode;
    logic [RFLD_W-1:0] rx;
    logic [RFLD_W-1:0] ry;
    logic [1:0]        spare;
  } instr_t;

endpackage

// File: rtl/instr_sequencer_if.sv
// Control bus between the instruction source and the sequencer.
//   master: drives EXECUTE/DIN, observes timestep and control decodes.
//   slave : the sequencer; receives EXECUTE/DIN, drives everything else.
interface instr_sequencer_if #(
  parameter int unsigned NREG = 4
) ();
  import proc_pkg::*;

  logic               EXECUTE;
  logic [INSTR_W-1:0] DIN;
  logic [TIME_W-1:0]  TIME;
  logic               DONE;
  logic [INSTR_W-1:0] IR;
  logic [NREG-1:0]    RIN;
  logic [NREG-1:0]    ROUT;
  logic               EXTRN;
  logic               AIN;
  logic               GIN;
  logic               GOUT;
  logic [1:0]         ALU_OP;

  modport master (
    output EXECUTE, DIN,
    input  TIME, DONE, IR, RIN, ROUT, EXTRN, AIN, GIN, GOUT, ALU_OP
  );

  modport slave (
    input  EXECUTE, DIN,
    output TIME, DONE, IR, RIN, ROUT, EXTRN, AIN, GIN, GOUT, ALU_OP
  );
endinterface

// File: rtl/timestep_counter.sv
// 2-bit timestep counter; clear has priority over enable.
//   clk, rst_n : clock, async active-low reset
//   clr, en    : synchronous clear / count enable
//   count      : current timestep
module timestep_counter
  import proc_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              en,
  output logic [TIME_W-1:0] count
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= count + TIME_W'(1);
    end
  end

endmodule

// File: rtl/instr_sequencer.sv
// Control-unit stage: latches an instruction on EXECUTE in T0 and steps the
// timestep counter, decoding register-file, bus and ALU controls from the
// current timestep and latched instruction only.
//   CLK, RSTb : clock, async active-low reset
//   bus       : slave side of instr_sequencer_if (EXECUTE/DIN in, controls out)
module instr_sequencer
  import proc_pkg::*;
#(
  parameter int unsigned NREG = 4
) (
  input  logic              CLK,
  input  logic              RSTb,
  instr_sequencer_if.slave  bus
);

  logic [TIME_W-1:0] time_q;
  instr_t            ir_q;
  logic              accept_c;
  logic              done_c;
  logic [NREG-1:0]   rx_oh_c;
  logic [NREG-1:0]   ry_oh_c;
  logic [NREG-1:0]   rin_c;
  logic [NREG-1:0]   rout_c;
  logic              extrn_c;
  logic              ain_c;
  logic              gin_c;
  logic              gout_c;
  alu_op_t           alu_op_c;

  // EXECUTE only matters while idle.
  assign accept_c = (time_q == T0) && bus.EXECUTE;

  // Instruction register; changes only on a T0 accept.
  always_ff @(posedge CLK or negedge RSTb) begin
    if (!RSTb) begin
      ir_q <= '0;
    end else if (accept_c) begin
      ir_q <= instr_t'(bus.DIN);
    end
  end

  // Counts up after an accept, returns to T0 on the edge after DONE.
  timestep_counter u_timestep_counter (
    .clk   (CLK),
    .rst_n (RSTb),
    .clr   (done_c),
    .en    (accept_c || (time_q != T0)),
    .count (time_q)
  );

  assign rx_oh_c = NREG'(1) << ir_q.rx;
  assign ry_oh_c = NREG'(1) << ir_q.ry;

  // Control decode from timestep and latched opcode.
  always_comb begin
    done_c   = 1'b0;
    rin_c    = '0;
    rout_c   = '0;
    extrn_c  = 1'b0;
    ain_c    = 1'b0;
    gin_c    = 1'b0;
    gout_c   = 1'b0;
    alu_op_c = ALU_ADD;
    case (time_q)
      T1: begin
        case (ir_q.opcode)
          OP_LOAD: begin
            extrn_c = 1'b1;
            rin_c   = rx_oh_c;
            done_c  = 1'b1;
          end
          OP_COPY: begin
            rout_c = ry_oh_c;
            rin_c  = rx_oh_c;
            done_c = 1'b1;
          end
          OP_ADD, OP_SUB, OP_INV: begin
            rout_c = rx_oh_c;
            ain_c  = 1'b1;
          end
          // Illegal opcodes terminate immediately without side effects.
          default: done_c = 1'b1;
        endcase
      end
      T2: begin
        case (ir_q.opcode)
          OP_ADD: begin
            rout_c   = ry_oh_c;
            gin_c    = 1'b1;
            alu_op_c = ALU_ADD;
          end
          OP_SUB: begin
            rout_c   = ry_oh_c;
            gin_c    = 1'b1;
            alu_op_c = ALU_SUB;
          end
          OP_INV: begin
            gin_c    = 1'b1;
            alu_op_c = ALU_INV;
          end
          default: ;
        endcase
      end
      T3: begin
        if (ir_q.opcode == OP_ADD || ir_q.opcode == OP_SUB || ir_q.opcode == OP_INV) begin
          gout_c = 1'b1;
          rin_c  = rx_oh_c;
          done_c = 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign bus.TIME   = time_q;
  assign bus.IR     = ir_q;
  assign bus.DONE   = done_c;
  assign bus.RIN    = rin_c;
  assign bus.ROUT   = rout_c;
  assign bus.EXTRN  = extrn_c;
  assign bus.AIN    = ain_c;
  assign bus.GIN    = gin_c;
  assign bus.GOUT   = gout_c;
  assign bus.ALU_OP = alu_op_c;

endmodule
